clock_buttons: RTL and testbench



---
 rtl/clock_pkg.sv | 16 +
 rtl/key_debounce.sv | 96 +++++++++
 rtl/clock_buttons.sv | 41 ++++
 tb/tb_clock_buttons.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the front-panel key conditioning block.
package clock_pkg;

  // Debounce FSM states, one instance per key channel.
  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_ARMING    = 2'd1,
    ST_HELD      = 2'd2,
    ST_DISARMING = 2'd3
  } key_state_e;

  // 10 ms of stability at 50 MHz.
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF           = 20;

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchroniser, stability counter and FSM producing
// a clean level (1 = pressed) and a one-cycle press pulse.
module key_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  // The counter starts at 0 on the first agreeing sample, so hitting
  // DEBOUNCE_CYCLES-2 while the sample still agrees means DEBOUNCE_CYCLES
  // consecutive agreeing samples; the counter would reach DEBOUNCE_CYCLES-1
  // on this cycle and is cleared instead, so it can never wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic       sync1_q, sync2_q;
  logic       s;
  key_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic       level_q, press_q;

  // Two-flop synchroniser; resets to the released (high) key level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  // Debounce FSM with registered level and press pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        ST_RELEASED: begin
          cnt_q <= '0;
          if (s) state_q <= ST_ARMING;
        end
        ST_ARMING: begin
          if (!s) begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HELD: begin
          cnt_q <= '0;
          if (!s) state_q <= ST_DISARMING;
        end
        ST_DISARMING: begin
          if (s) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_RELEASED;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/clock_buttons.sv
// Front-panel key conditioning for the clock generator: mode key and
// manual single-step key, each through an independent debounce channel.
module clock_buttons
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iKEY_MODE_N,
  input  logic iKEY_STEP_N,
  output logic oMODE_CLK,
  output logic oMODE_PRESS,
  output logic oMANUAL_CLK,
  output logic oSTEP_PRESS
);

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_mode (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .key_n_i(iKEY_MODE_N),
    .level_o(oMODE_CLK),
    .press_o(oMODE_PRESS)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_step (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .key_n_i(iKEY_STEP_N),
    .level_o(oMANUAL_CLK),
    .press_o(oSTEP_PRESS)
  );

endmodule

// File: tb/tb_clock_buttons.sv
// Bench for clock_buttons: directed scenarios plus random key activity,
// every cycle compared against a history-based reference model.
module tb_clock_buttons;

  localparam int D  = 8;
  localparam int CW = 4;
  localparam int NC = 4096;

  logic clk = 1'b0;
  logic iRST, km, ks;
  logic oMODE_CLK, oMODE_PRESS, oMANUAL_CLK, oSTEP_PRESS;

  clock_buttons #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .iCLK       (clk),
    .iRST       (iRST),
    .iKEY_MODE_N(km),
    .iKEY_STEP_N(ks),
    .oMODE_CLK  (oMODE_CLK),
    .oMODE_PRESS(oMODE_PRESS),
    .oMANUAL_CLK(oMANUAL_CLK),
    .oSTEP_PRESS(oSTEP_PRESS)
  );

  always #5 clk = ~clk;

  // History per cycle: raw key (index 0 = mode, 1 = step), reset, and the
  // pressed-sample the channel sees on the edge that ends that cycle.
  bit raw_h [2][NC];
  bit samp_h[2][NC];
  bit rst_h [NC];
  bit lvl[2], pls[2];
  int cyc;
  int n_cmp = 0, n_bad = 0;
  int mode_press_cnt = 0, step_press_cnt = 0;
  int mode_press_cyc = -1, step_press_cyc = -1, step_fall_cyc = -1;
  logic prev_step_lvl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, act, exp);
    end
  endtask

  // Reference: a channel's level flips once the last D samples all disagree
  // with it; a pressed sample exists only when the raw key was low three
  // edges back and no reset touched the synchroniser since.
  function automatic void model_edge(int c);
    for (int ch = 0; ch < 2; ch++) begin
      if (rst_h[c-1]) begin
        lvl[ch] = 1'b0;
        pls[ch] = 1'b0;
        samp_h[ch][c] = 1'b0;
      end else begin
        bit all_opp;
        samp_h[ch][c] = !rst_h[c-3] && !rst_h[c-2] && !raw_h[ch][c-3];
        all_opp = 1'b1;
        for (int k = c - D + 1; k <= c; k++)
          if (samp_h[ch][k] == lvl[ch]) all_opp = 1'b0;
        pls[ch] = all_opp && !lvl[ch];
        if (all_opp) lvl[ch] = !lvl[ch];
      end
    end
  endfunction

  task automatic tick(input bit m, input bit s, input bit r);
    @(posedge clk);
    cyc++;
    model_edge(cyc);
    #1;
    km = m; ks = s; iRST = r;
    raw_h[0][cyc] = m; raw_h[1][cyc] = s; rst_h[cyc] = r;
    @(negedge clk);
    chk("mode_lvl",   oMODE_CLK,   r ? 1'b0 : lvl[0]);
    chk("mode_press", oMODE_PRESS, r ? 1'b0 : pls[0]);
    chk("step_lvl",   oMANUAL_CLK, r ? 1'b0 : lvl[1]);
    chk("step_press", oSTEP_PRESS, r ? 1'b0 : pls[1]);
    if (oMODE_PRESS === 1'b1) begin mode_press_cnt++; mode_press_cyc = cyc; end
    if (oSTEP_PRESS === 1'b1) begin step_press_cnt++; step_press_cyc = cyc; end
    if (prev_step_lvl === 1'b1 && oMANUAL_CLK === 1'b0) step_fall_cyc = cyc;
    prev_step_lvl = oMANUAL_CLK;
  endtask

  task automatic run(input bit m, input bit s, input bit r, input int n);
    for (int i = 0; i < n; i++) tick(m, s, r);
  endtask

  initial begin
    int t0, sp0, mp0;
    bit rm, rs;
    int rst_left;
    iRST = 1'b1; km = 1'b1; ks = 1'b1;
    for (int i = 0; i < NC; i++) begin
      raw_h[0][i] = 1'b1; raw_h[1][i] = 1'b1; rst_h[i] = 1'b1;
      samp_h[0][i] = 1'b0; samp_h[1][i] = 1'b0;
    end
    lvl = '{1'b0, 1'b0}; pls = '{1'b0, 1'b0};
    cyc = D + 3;

    // Reset hold, then idle keys: nothing moves.
    run(1, 1, 1, 5);
    chk("rst_mode_lvl", oMODE_CLK, 1'b0);
    chk("rst_step_lvl", oMANUAL_CLK, 1'b0);
    run(1, 1, 0, 50);
    chk("idle_presses", mode_press_cnt + step_press_cnt, 0);

    // Clean step press and release.
    t0 = cyc + 1;
    run(1, 0, 0, 40);
    chk("step_press_lat", step_press_cyc - t0, D + 2);
    chk("step_press_cnt", step_press_cnt, 1);
    t0 = cyc + 1;
    run(1, 1, 0, 30);
    chk("step_rel_lat", step_fall_cyc - t0, D + 2);
    chk("step_rel_nopulse", step_press_cnt, 1);

    // Bouncing mode key, then held low.
    mp0 = mode_press_cnt;
    for (int b = 0; b < 5; b++) begin
      run(0, 1, 0, 3);
      run(1, 1, 0, 3);
    end
    chk("bounce_nopress", mode_press_cnt - mp0, 0);
    t0 = cyc + 1;
    run(0, 1, 0, 20);
    chk("bounce_presses", mode_press_cnt - mp0, 1);
    chk("bounce_lat", mode_press_cyc - t0, D + 2);
    run(1, 1, 0, 20);

    // Both keys together.
    t0 = cyc + 1;
    run(0, 0, 0, 20);
    chk("simul_mode_lat", mode_press_cyc - t0, D + 2);
    chk("simul_same_cyc", step_press_cyc, mode_press_cyc);
    run(1, 1, 0, 20);

    // Reset mid-debounce with the key still held: a fresh press follows.
    sp0 = step_press_cnt;
    run(1, 0, 0, 9);
    run(1, 0, 1, 3);
    t0 = cyc + 1;
    run(1, 0, 0, 20);
    chk("rstmid_presses", step_press_cnt - sp0, 1);
    chk("rstmid_lat", step_press_cyc - t0, D + 2);
    run(1, 1, 0, 20);

    // Near-threshold glitches on the step key.
    sp0 = step_press_cnt;
    run(1, 0, 0, D - 1);
    run(1, 1, 0, 20);
    chk("glitch7_presses", step_press_cnt - sp0, 0);
    t0 = cyc + 1;
    run(1, 0, 0, D);
    run(1, 1, 0, 30);
    chk("glitch8_presses", step_press_cnt - sp0, 1);
    chk("glitch8_rel", step_fall_cyc - step_press_cyc, D);

    // Random bouncing on both keys with occasional resets.
    rm = 1'b1; rs = 1'b1; rst_left = 0;
    for (int i = 0; i < 2500 && cyc < NC - 2; i++) begin
      if ($urandom_range(0, 5) == 0) rm = !rm;
      if ($urandom_range(0, 5) == 0) rs = !rs;
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
      tick(rm, rs, rst_left != 0);
      if (rst_left != 0) rst_left--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
